// File: rtl/mux_scan_nto1.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_nto1
// Description : Registered N-channel, W-bit multiplexer with manual select
//               and prescaled auto-scan over an enable mask.
// Revision    : 1.0 - initial release
// ============================================================================

module mux_scan_nto1 #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DIV      = 50000000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       enable_mask,
    input  logic                      hold,
    output logic [SEL_W-1:0]          cur_sel,
    output logic [WIDTH-1:0]          data_out,
    output logic                      switch_pulse
);

    localparam int                c_pre_w      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last  = c_pre_w'(DIV - 1);
    localparam logic [SEL_W:0]    c_chan_count = (SEL_W + 1)'(CHANNELS);

    logic [c_pre_w-1:0] r_prescaler;
    logic [c_pre_w-1:0] w_prescaler_next;
    logic               w_counting;
    logic               w_tick;
    logic [SEL_W:0]     w_probe;
    logic [SEL_W-1:0]   w_scan_sel;
    logic               w_scan_found;
    logic [SEL_W-1:0]   w_sel_next;
    logic [WIDTH-1:0]   w_chan [CHANNELS];

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_unpack
            assign w_chan[k] = data_in[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_counting = mode & ~hold;
    assign w_tick     = w_counting && (r_prescaler == c_pre_last);

    always_comb begin
        w_prescaler_next = r_prescaler;
        if (!mode) begin
            w_prescaler_next = '0;
        end else if (!hold) begin
            if (w_tick) begin
                w_prescaler_next = '0;
            end else begin
                w_prescaler_next = r_prescaler + 1'b1;
            end
        end
    end

    // Circular search for the next enabled channel, starting one past the
    // current one; the current channel itself is never a candidate.
    always_comb begin
        w_probe      = '0;
        w_scan_sel   = cur_sel;
        w_scan_found = 1'b0;
        for (int i = 1; i < CHANNELS; i++) begin
            w_probe = {1'b0, cur_sel} + (SEL_W + 1)'(i);
            if (w_probe >= c_chan_count) begin
                w_probe = w_probe - c_chan_count;
            end
            if (!w_scan_found && enable_mask[w_probe[SEL_W-1:0]]) begin
                w_scan_found = 1'b1;
                w_scan_sel   = w_probe[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_next = cur_sel;
        if (!hold) begin
            if (!mode) begin
                if ({1'b0, sel} < c_chan_count) begin
                    w_sel_next = sel;
                end
            end else if (w_tick && w_scan_found) begin
                w_sel_next = w_scan_sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prescaler  <= '0;
            cur_sel      <= '0;
            data_out     <= '0;
            switch_pulse <= 1'b0;
        end else begin
            r_prescaler  <= w_prescaler_next;
            cur_sel      <= w_sel_next;
            data_out     <= w_chan[cur_sel];
            switch_pulse <= (w_sel_next != cur_sel);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_nto1.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_nto1
// Description : Directed self-checking bench for mux_scan_nto1.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mux_scan_nto1;

    localparam int N = 4;
    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic [1:0]  sel;
    logic        mode;
    logic [3:0]  mask;
    logic        hold;
    logic [1:0]  cur_sel;
    logic [3:0]  data_out;
    logic        switch_pulse;

    logic [11:0] data_in3;
    logic [1:0]  sel3;
    logic [1:0]  cur_sel3;
    logic [3:0]  data_out3;
    logic        pulse3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    mux_scan_nto1 #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DIV(D)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .sel(sel),
        .mode(mode), .enable_mask(mask), .hold(hold),
        .cur_sel(cur_sel), .data_out(data_out), .switch_pulse(switch_pulse)
    );

    mux_scan_nto1 #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DIV(D)) dut3 (
        .clock(clock), .reset(reset), .data_in(data_in3), .sel(sel3),
        .mode(1'b0), .enable_mask(3'b111), .hold(1'b0),
        .cur_sel(cur_sel3), .data_out(data_out3), .switch_pulse(pulse3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    // Reference model: selection rules evaluated with plain modulo arithmetic.
    int          m_sel = 0;
    int          m_pre = 0;
    logic [3:0]  m_out = 4'h0;
    bit          m_pulse = 1'b0;

    always @(posedge clock) begin
        int nxt;
        if (reset) begin
            m_sel = 0; m_pre = 0; m_out = 4'h0; m_pulse = 1'b0;
        end else begin
            nxt   = m_sel;
            m_out = data_in[m_sel*4 +: 4];
            if (!hold && !mode && int'(sel) < N) nxt = int'(sel);
            if (!hold && mode && m_pre == D - 1) begin
                for (int d = 1; d < N; d++)
                    if (nxt == m_sel && mask[(m_sel + d) % N]) nxt = (m_sel + d) % N;
            end
            if (!mode)      m_pre = 0;
            else if (!hold) m_pre = (m_pre + 1) % D;
            m_pulse = (nxt != m_sel);
            m_sel   = nxt;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cmp_sel",   32'(cur_sel),      32'(m_sel));
            chk("cmp_out",   32'(data_out),     32'(m_out));
            chk("cmp_pulse", 32'(switch_pulse), 32'(m_pulse));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mode = 1'b0; hold = 1'b0; sel = 2'd0; mask = 4'hF;
        data_in = 16'hDCBA; data_in3 = 12'hCBA; sel3 = 2'd2;
        @(posedge clock);
        #1 chk_en = 1'b1;
        edges(1);
        chk("rst_sel",   32'(cur_sel),      0);
        chk("rst_out",   32'(data_out),     0);
        chk("rst_pulse", 32'(switch_pulse), 0);

        // Manual select
        reset = 1'b0; sel = 2'd2;
        edges(1);
        chk("man_sel2",   32'(cur_sel), 2);
        chk("man_pulse2", 32'(switch_pulse), 1);
        sel = 2'd3;
        edges(1);
        chk("man_sel3", 32'(cur_sel), 3);
        chk("man_outC", 32'(data_out), 32'hC);
        sel = 2'd0;
        edges(1);
        chk("man_sel0", 32'(cur_sel), 0);
        chk("man_outD", 32'(data_out), 32'hD);
        edges(1);
        chk("man_outA",   32'(data_out), 32'hA);
        chk("man_nopulse", 32'(switch_pulse), 0);

        // Three-channel instance: out-of-range select is ignored
        chk("c3_sel2", 32'(cur_sel3), 2);
        chk("c3_outC", 32'(data_out3), 32'hC);
        sel3 = 2'd3;
        edges(2);
        chk("c3_oor_sel",   32'(cur_sel3), 2);
        chk("c3_oor_pulse", 32'(pulse3), 0);

        // Auto-scan, full mask
        mode = 1'b1; mask = 4'hF;
        edges(3);
        chk("auto_pre_step", 32'(cur_sel), 0);
        edges(1);
        chk("auto_step1",  32'(cur_sel), 1);
        chk("auto_pulse1", 32'(switch_pulse), 1);
        edges(1);
        chk("auto_outB", 32'(data_out), 32'hB);
        edges(15);
        chk("auto_20cyc", 32'(cur_sel), 1);

        // Sparse mask with wrap
        mode = 1'b0; sel = 2'd0;
        edges(1);
        chk("sp_start", 32'(cur_sel), 0);
        mode = 1'b1; mask = 4'b1010;
        edges(4); chk("sp_a", 32'(cur_sel), 1);
        edges(4); chk("sp_b", 32'(cur_sel), 3);
        edges(4); chk("sp_c", 32'(cur_sel), 1);
        edges(4); chk("sp_d", 32'(cur_sel), 3);

        // Only the current channel enabled, then nothing enabled
        mode = 1'b0; sel = 2'd2;
        edges(1);
        mode = 1'b1; mask = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            edges(1);
            chk("solo_nopulse", 32'(switch_pulse), 0);
        end
        chk("solo_sel", 32'(cur_sel), 2);
        mask = 4'b0000;
        edges(8);
        chk("empty_sel", 32'(cur_sel), 2);
        mask = 4'b1010;
        edges(4);
        chk("disabled_steps", 32'(cur_sel), 3);
        chk("disabled_pulse", 32'(switch_pulse), 1);

        // Hold mid-count in auto mode
        edges(2);
        hold = 1'b1;
        edges(10);
        chk("hold_frozen", 32'(cur_sel), 3);
        hold = 1'b0;
        edges(1);
        chk("hold_rel1", 32'(cur_sel), 3);
        edges(1);
        chk("hold_rel2", 32'(cur_sel), 1);

        // Hold in manual mode ignores sel
        mode = 1'b0; hold = 1'b1; sel = 2'd0;
        edges(1); sel = 2'd2;
        edges(1); sel = 2'd3;
        edges(1);
        chk("mhold_sel", 32'(cur_sel), 1);
        hold = 1'b0; sel = 2'd2;
        edges(1);
        chk("mhold_rel", 32'(cur_sel), 2);

        // Reset landing on a tick with cur_sel=3
        sel = 2'd3;
        edges(1);
        chk("rt_pre", 32'(cur_sel), 3);
        mode = 1'b1; mask = 4'hF;
        edges(3);
        reset = 1'b1;
        edges(1);
        chk("rt_sel",   32'(cur_sel), 0);
        chk("rt_out",   32'(data_out), 0);
        chk("rt_pulse", 32'(switch_pulse), 0);
        reset = 1'b0;
        edges(3);
        chk("rt_wait", 32'(cur_sel), 0);
        edges(1);
        chk("rt_step", 32'(cur_sel), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_scan_nto1.md
Name: mux_scan_nto1

Overview:
- Parametrised, registered N-channel, W-bit multiplexer; successor to the 2:1 and 4:1 switch-driven muxes.
- Two modes:
  - Manual: an external select picks the channel.
  - Auto-scan: a prescaled tick steps through the channels that the enable mask allows.
- Sits between switch/data inputs and LED/HEX display logic so one display can cycle through several sources.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 4, number of input channels; legal range is 2 or more.
- SEL_W, 2, select width; must equal ceil(log2(CHANNELS)).
- DIV, 50000000, clock cycles per scan step in auto mode; legal range is 1 or more.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- enable_mask  in  CHANNELS  bit k = 1 means channel k takes part in auto-scan.
- hold  in  1  freezes cur_sel and the prescaler.
- cur_sel  out  SEL_W  currently selected channel index.
- data_out  out  WIDTH  registered mux output.
- switch_pulse  out  1  one-cycle strobe when cur_sel changes value.

Behaviour:
- Reset (reset=1 at an edge):
  - cur_sel=0, data_out=0, switch_pulse=0, prescaler=0.
  - Reset overrides every other input.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0. tick = (prescaler == DIV-1) and counting.
  - Counts only when mode=1 and hold=0.
  - Forced to 0 when mode=0. Holds its value when hold=1.
  - DIV=1: tick is asserted every counting cycle.
- Manual mode (mode=0, hold=0):
  - Each edge, cur_sel <= sel when sel < CHANNELS.
  - Out-of-range sel leaves cur_sel unchanged.
  - enable_mask is ignored.
- Auto mode (mode=1, hold=0), on a tick:
  - cur_sel <= first index j in the order cur_sel+1, cur_sel+2, … (mod CHANNELS) with enable_mask[j]=1.
  - The search examines at most CHANNELS-1 other indices.
  - Wrap: CHANNELS-1 advances to the lowest enabled index.
  - If only cur_sel is enabled, or enable_mask=0, cur_sel is unchanged.
  - A disabled current channel still steps forward at the next tick.
  - Between ticks, cur_sel is stable.
- Hold:
  - hold=1 freezes cur_sel in both modes.
  - In manual mode, sel is ignored while hold=1.
  - On hold falling, behaviour resumes: auto mode continues from the frozen prescaler value; manual mode takes sel at the next edge.
- Mode switch:
  - 1->0: manual load of sel on the same edge mode=0 is sampled.
  - 0->1: the first tick occurs DIV edges later (prescaler starts from 0).
- data_out:
  - data_out(n+1) = channel cur_sel(n) of data_in(n).
  - One-cycle latency behind cur_sel; it tracks live data_in changes on the current channel.
- switch_pulse:
  - Registered. Equals 1 for exactly the cycle after an edge on which cur_sel took a different value.
  - Equals 0 when a load or tick leaves cur_sel the same.
- Simultaneous reset + tick: reset wins, and no switch_pulse is produced.
- All logic is synchronous; there are no combinational paths from inputs to outputs.

Test Plan:
All scenarios use CHANNELS=4, WIDTH=4, DIV=4 and data_in = {4'hD, 4'hC, 4'hB, 4'hA} (ch3..ch0).
- Manual select:
  - Stimulus: reset for 2 cycles, then mode=0 with sel = 2, 3, 0.
  - Required response: cur_sel follows sel one edge later; data_out = C, D, A one cycle after each cur_sel; switch_pulse on each change.
- Auto-scan, full mask:
  - Stimulus: mode=1, enable_mask=4'b1111, hold=0, for 20 cycles.
  - Required response: cur_sel steps 0->1->2->3->0 every 4 cycles; the first step occurs 4 edges after mode rises; data_out = A, B, C, D, A with 1-cycle lag.
- Sparse mask and wrap:
  - Stimulus: enable_mask=4'b1010, starting from cur_sel=0.
  - Required response: sequence 1, 3, 1, 3…
  - Stimulus: enable_mask=4'b0100 while cur_sel=2.
  - Required response: cur_sel stays 2 and switch_pulse never asserts.
  - Stimulus: enable_mask=0.
  - Required response: cur_sel is frozen.
- Hold:
  - Stimulus: auto mode, assert hold for 10 cycles mid-count (prescaler=2), then release.
  - Required response: no change during hold; next step occurs exactly 2 cycles after release.
  - Stimulus: hold=1 in manual mode with sel changing.
  - Required response: cur_sel unchanged.
- Reset mid-operation and corner cases:
  - Stimulus: synchronous reset during auto-scan with cur_sel=3 on a tick cycle.
  - Required response: next cycle cur_sel=0, data_out=0, switch_pulse=0; the scan restarts with the first step 4 cycles after reset deasserts.
  - Stimulus (with CHANNELS=3): sel=3.
  - Required response: cur_sel unchanged.
